conbus_rr_arbiter: RTL and testbench

- Round-robin bus arbiter with a transfer watchdog for the 7-master shared Wishbone interconnect.
- Grants exactly one master the shared bus and holds the grant for that master's whole cycle (cyc high).
- If a selected slave never acks, it aborts the stalled transfer: one-cycle error pulse to the owning master, then the bus is isolated until that master releases cyc.
- Drives the interconnect's one-hot gnt vector. Consumes per-master cyc/stb and the OR'd slave ack.

---
 rtl/conbus_rr_arbiter_if.sv | 25 ++
 rtl/conbus_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_conbus_rr_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/conbus_rr_arbiter_if.sv
// Arbiter-side bundle for the 7-master shared Wishbone interconnect.
// Latency: none, wires only.
// Backpressure: none; the grant is ownership and requesters hold cyc until they are done.
interface conbus_rr_arbiter_if;
  logic [6:0] req;          // per-master cyc
  logic [6:0] stb;          // per-master stb
  logic       bus_ack;      // OR of all slave acks
  logic [6:0] gnt;          // one-hot grant, zero when the bus is unowned
  logic [2:0] gnt_id;       // index of the granted master
  logic [6:0] err;          // one-cycle abort pulse to the owning master
  logic       timeout_evt;  // one-cycle pulse alongside err
  logic [2:0] abort_id;     // master most recently aborted

  // master: the arbiter, which drives the grant side of the bundle
  modport master (
    input  req, stb, bus_ack,
    output gnt, gnt_id, err, timeout_evt, abort_id
  );

  // slave: the requesters and interconnect, which consume the grant
  modport slave (
    output req, stb, bus_ack,
    input  gnt, gnt_id, err, timeout_evt, abort_id
  );
endinterface

// File: rtl/conbus_rr_arbiter.sv
// Round-robin bus arbiter with a stalled-transfer watchdog for 7 Wishbone masters.
// Latency: grant is registered 1 cycle after req; owner handover happens with no idle cycle.
// Backpressure: no preemption; the owner keeps the bus until it drops cyc or the watchdog aborts.
module conbus_rr_arbiter #(
  parameter int N_MASTERS = 7,     // the port widths are fixed at 7 in this revision
  parameter int TIMEOUT   = 1024,  // stalled-strobe cycles before abort; 0 disables
  parameter int TO_W      = 16     // watchdog width; TIMEOUT < 2**TO_W
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  conbus_rr_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_e;

  localparam logic            WD_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  // Round-robin pick. The scan starts at lst+1 and wraps modulo N_MASTERS.
  // The loop runs from the lowest priority to the highest, so the last hit wins.
  // The return value is {found, index}.
  function automatic logic [3:0] rr_pick(input logic [6:0] r, input logic [2:0] lst);
    logic [3:0] res;
    int         idx;
    res = 4'd0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      idx = (int'(lst) + i) % N_MASTERS;
      if (r[3'(idx)]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  state_e          state_q, state_d;
  logic [6:0]      gnt_q, gnt_d;
  logic [2:0]      gnt_id_q, gnt_id_d;
  logic [6:0]      err_q, err_d;
  logic            tevt_q, tevt_d;
  logic [2:0]      abort_id_q, abort_id_d;
  logic [2:0]      last_q, last_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [6:0] own_oh;
  logic [3:0] pick_idle, pick_own, pick_abort;
  logic       do_grant;
  logic [2:0] win;

  assign own_oh     = 7'd1 << gnt_id_q;
  assign pick_idle  = rr_pick(bus.req, last_q);
  // On handover the current owner is masked out. last_q already equals the owner's index.
  assign pick_own   = rr_pick(bus.req & ~own_oh, last_q);
  // After an abort the aborted master is given the lowest priority.
  assign pick_abort = rr_pick(bus.req, abort_id_q);

  // Next-state logic: arbitration, handover, watchdog and abort isolation.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    err_d      = 7'd0;
    tevt_d     = 1'b0;
    abort_id_d = abort_id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    do_grant   = 1'b0;
    win        = 3'd0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_idle[3]) begin
          do_grant = 1'b1;
          win      = pick_idle[2:0];
        end
      end

      OWN: begin
        if (!bus.req[gnt_id_q]) begin
          // The owner released cyc. Hand the bus over directly or go idle.
          cnt_d = '0;
          if (pick_own[3]) begin
            do_grant = 1'b1;
            win      = pick_own[2:0];
          end else begin
            gnt_d   = 7'd0;
            state_d = IDLE;
          end
        end else if (bus.bus_ack || !bus.stb[gnt_id_q]) begin
          // Progress was made, or no strobe is pending. An ack on the threshold cycle also wins.
          cnt_d = '0;
        end else if (WD_EN) begin
          if (cnt_q == TO_LAST) begin
            err_d      = own_oh;
            tevt_d     = 1'b1;
            abort_id_d = gnt_id_q;
            gnt_d      = 7'd0;
            cnt_d      = '0;
            state_d    = ABORT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ABORT: begin
        // gnt stays zero, so a late slave ack cannot reach any master.
        cnt_d = '0;
        if (!bus.req[abort_id_q]) begin
          if (pick_abort[3]) begin
            do_grant = 1'b1;
            win      = pick_abort[2:0];
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      gnt_d    = 7'd1 << win;
      gnt_id_d = win;
      last_d   = win;
      cnt_d    = '0;
      state_d  = OWN;
    end
  end

  // State register. The asynchronous reset drops the grant and any abort pulse at once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 7'd0;
      gnt_id_q   <= 3'd0;
      err_q      <= 7'd0;
      tevt_q     <= 1'b0;
      abort_id_q <= 3'd0;
      last_q     <= 3'd6;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      err_q      <= err_d;
      tevt_q     <= tevt_d;
      abort_id_q <= abort_id_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.err         = err_q;
  assign bus.timeout_evt = tevt_q;
  assign bus.abort_id    = abort_id_q;

endmodule

// File: tb/tb_conbus_rr_arbiter.sv
// Directed bench for conbus_rr_arbiter, configured with TIMEOUT=8.
// Expected outputs are queued when stimulus is applied and compared after the next edge.
// All wait lengths are fixed cycle counts, so the run always ends on its own.
module tb_conbus_rr_arbiter;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  conbus_rr_arbiter_if bus();

  conbus_rr_arbiter #(
    .N_MASTERS(7),
    .TIMEOUT  (8),
    .TO_W     (16)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  // 10 ns clock period.
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string      tag;
    logic [6:0] gnt;
    logic [2:0] id;
    logic [6:0] err;
    logic       tevt;
    logic [2:0] aid;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks = checks + 1;
    assert (obs === expv) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [6:0] g, input logic [2:0] id,
                      input logic [6:0] er, input logic tv, input logic [2:0] aid);
    exp_t e;
    e.tag  = tag;
    e.gnt  = g;
    e.id   = id;
    e.err  = er;
    e.tevt = tv;
    e.aid  = aid;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".gnt"},      bus.gnt,                 e.gnt);
    chk({e.tag, ".gnt_id"},   7'(bus.gnt_id),          7'(e.id));
    chk({e.tag, ".err"},      bus.err,                 e.err);
    chk({e.tag, ".tevt"},     7'(bus.timeout_evt),     7'(e.tevt));
    chk({e.tag, ".abort_id"}, 7'(bus.abort_id),        7'(e.aid));
  endtask

  // Queue the expectation, let one rising edge pass, then compare.
  task automatic cyc(input string tag, input logic [6:0] g, input logic [2:0] id,
                     input logic [6:0] er, input logic tv, input logic [2:0] aid);
    push(tag, g, id, er, tv, aid);
    @(posedge sys_clk);
    #1;
    compare_front();
  endtask

  // Queue the expectation and compare right away, with no edge in between (used around reset).
  task automatic now(input string tag, input logic [6:0] g, input logic [2:0] id,
                     input logic [6:0] er, input logic tv, input logic [2:0] aid);
    push(tag, g, id, er, tv, aid);
    compare_front();
  endtask

  task automatic drive(input logic [6:0] r, input logic [6:0] s, input logic a);
    bus.req     = r;
    bus.stb     = s;
    bus.bus_ack = a;
  endtask

  initial begin
    int         order [8];
    logic [6:0] oh_cur;
    logic [6:0] oh_nxt;
    order = '{0, 1, 2, 3, 4, 5, 6, 0};

    // Reset values.
    sys_rst_n = 1'b0;
    drive(7'h00, 7'h00, 1'b0);
    #7;
    now("rst0", 7'h00, 3'd0, 7'h00, 1'b0, 3'd0);
    #5;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // A single request is granted after one cycle and released after one cycle.
    drive(7'h01, 7'h00, 1'b0);
    cyc("s1_gnt", 7'h01, 3'd0, 7'h00, 1'b0, 3'd0);
    drive(7'h00, 7'h00, 1'b0);
    cyc("s1_rel", 7'h00, 3'd0, 7'h00, 1'b0, 3'd0);

    // Reset again so the round-robin pointer starts from master 0.
    sys_rst_n = 1'b0;
    #2;
    now("rst1", 7'h00, 3'd0, 7'h00, 1'b0, 3'd0);
    #2;
    sys_rst_n = 1'b1;

    // All masters request. Each owner takes two acks, drops cyc for one edge, then re-raises it.
    drive(7'h7F, 7'h00, 1'b0);
    cyc("rr_first", 7'h01, 3'd0, 7'h00, 1'b0, 3'd0);
    for (int k = 0; k < 7; k++) begin
      oh_cur = 7'd1 << order[k];
      oh_nxt = 7'd1 << order[k + 1];
      drive(7'h7F, oh_cur, 1'b1);
      cyc("rr_ack1", oh_cur, 3'(order[k]), 7'h00, 1'b0, 3'd0);
      cyc("rr_ack2", oh_cur, 3'(order[k]), 7'h00, 1'b0, 3'd0);
      drive(7'h7F & ~oh_cur, 7'h00, 1'b0);
      cyc("rr_switch", oh_nxt, 3'(order[k + 1]), 7'h00, 1'b0, 3'd0);
    end
    drive(7'h00, 7'h00, 1'b0);
    cyc("rr_end", 7'h00, 3'd0, 7'h00, 1'b0, 3'd0);

    // No preemption: master 5 waits until master 2 drops cyc.
    drive(7'h04, 7'h00, 1'b0);
    cyc("np_gnt2", 7'h04, 3'd2, 7'h00, 1'b0, 3'd0);
    drive(7'h24, 7'h04, 1'b1);
    cyc("np_hold_a", 7'h04, 3'd2, 7'h00, 1'b0, 3'd0);
    cyc("np_hold_b", 7'h04, 3'd2, 7'h00, 1'b0, 3'd0);
    drive(7'h20, 7'h00, 1'b0);
    cyc("np_gnt5", 7'h20, 3'd5, 7'h00, 1'b0, 3'd0);
    drive(7'h00, 7'h00, 1'b0);
    cyc("np_end", 7'h00, 3'd5, 7'h00, 1'b0, 3'd0);

    // Watchdog: master 3 stalls. It is aborted on the 8th stall edge, the bus stays isolated,
    // and master 4 takes over.
    drive(7'h08, 7'h00, 1'b0);
    cyc("wd_gnt3", 7'h08, 3'd3, 7'h00, 1'b0, 3'd0);
    for (int i = 0; i < 7; i++) begin
      drive(7'h18, 7'h08, 1'b0);
      cyc("wd_stall", 7'h08, 3'd3, 7'h00, 1'b0, 3'd0);
    end
    cyc("wd_abort", 7'h00, 3'd3, 7'h08, 1'b1, 3'd3);
    cyc("wd_iso_a", 7'h00, 3'd3, 7'h00, 1'b0, 3'd3);
    cyc("wd_iso_b", 7'h00, 3'd3, 7'h00, 1'b0, 3'd3);
    drive(7'h10, 7'h00, 1'b0);
    cyc("wd_gnt4", 7'h10, 3'd4, 7'h00, 1'b0, 3'd3);
    drive(7'h00, 7'h00, 1'b0);
    cyc("wd_end", 7'h00, 3'd4, 7'h00, 1'b0, 3'd3);

    // An ack on the threshold cycle beats the abort. The count then restarts from zero.
    drive(7'h40, 7'h00, 1'b0);
    cyc("ak_gnt6", 7'h40, 3'd6, 7'h00, 1'b0, 3'd3);
    for (int i = 0; i < 7; i++) begin
      drive(7'h40, 7'h40, 1'b0);
      cyc("ak_stall", 7'h40, 3'd6, 7'h00, 1'b0, 3'd3);
    end
    drive(7'h40, 7'h40, 1'b1);
    cyc("ak_thr_ack", 7'h40, 3'd6, 7'h00, 1'b0, 3'd3);
    for (int i = 0; i < 7; i++) begin
      drive(7'h40, 7'h40, 1'b0);
      cyc("ak_restall", 7'h40, 3'd6, 7'h00, 1'b0, 3'd3);
    end
    cyc("ak_abort", 7'h00, 3'd6, 7'h40, 1'b1, 3'd6);
    drive(7'h00, 7'h00, 1'b0);
    cyc("ak_exit", 7'h00, 3'd6, 7'h00, 1'b0, 3'd6);

    // Asynchronous reset while master 1 owns the bus mid-stall.
    drive(7'h02, 7'h00, 1'b0);
    cyc("ar_gnt1", 7'h02, 3'd1, 7'h00, 1'b0, 3'd6);
    for (int i = 0; i < 5; i++) begin
      drive(7'h02, 7'h02, 1'b0);
      cyc("ar_stall", 7'h02, 3'd1, 7'h00, 1'b0, 3'd6);
    end
    #3;
    sys_rst_n = 1'b0;
    #1;
    now("ar_rst", 7'h00, 3'd0, 7'h00, 1'b0, 3'd0);
    drive(7'h03, 7'h00, 1'b0);
    #2;
    sys_rst_n = 1'b1;
    cyc("ar_first", 7'h01, 3'd0, 7'h00, 1'b0, 3'd0);
    drive(7'h00, 7'h00, 1'b0);
    cyc("ar_end", 7'h00, 3'd0, 7'h00, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
